// File: rtl/fmul_prod_r4.sv
// fmul_prod_r4: two-stage binary32 multiplier front end producing the exact,
// unrounded 48-bit significand product and biased exponent for faddsub_r4.

package exe_bus_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  fpu_op;
        logic [4:0]  rd;
        logic        reg_write;
        logic        FP_reg_write;
    } exe_p_mux_bus_type;
endpackage

module fmul_prod_r4
    import exe_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        clear,
    input  logic [31:0]       num1,
    input  logic [31:0]       num2,
    input  logic              p_start,
    output logic              p_result,
    input  exe_p_mux_bus_type fmul_pipeline_signals_i,
    output exe_p_mux_bus_type fmul_pipeline_signals_o,
    output logic              prod_sign,
    output logic [9:0]        prod_exp,
    output logic [47:0]       prod_mant,
    output logic              prod_is_NaN,
    output logic              prod_is_inf,
    output logic              prod_is_zero,
    output logic [4:0]        uu_rd [0:1],
    output logic [1:0]        uu_reg_write,
    output logic [1:0]        uu_FP_reg_write
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  ee;
        logic [23:0] m;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
    } operand_t;

    typedef struct packed {
        logic              valid;
        exe_p_mux_bus_type meta;
        operand_t          a;
        operand_t          b;
    } s1_t;

    typedef struct packed {
        logic              valid;
        exe_p_mux_bus_type meta;
        logic              sign;
        logic [9:0]        exp;
        logic [47:0]       mant;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } s2_t;

    function automatic operand_t unpack_operand(input logic [31:0] x);
        operand_t o;
        o.sign    = x[31];
        o.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        o.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        o.is_zero = (x[30:0] == 31'd0);
        o.m       = {x[30:23] != 8'h00, x[22:0]};
        // Subnormals share the exponent of the smallest normal; the hidden bit carries the difference.
        o.ee      = (x[30:23] == 8'h00) ? 8'd1 : x[30:23];
        return o;
    endfunction

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s2_t  prod;
    logic prod_nan, prod_inf, prod_zero;

    always_comb begin
        // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
        s1_d = s1_q;
        if (clear[0]) begin
            s1_d = '0;
        end else if (en) begin
            s1_d = '0;
            if (p_start) begin
                s1_d.valid = 1'b1;
                s1_d.meta  = fmul_pipeline_signals_i;
                s1_d.a     = unpack_operand(num1);
                s1_d.b     = unpack_operand(num2);
            end
        end
    end

    always_comb begin
        prod_nan  = s1_q.a.is_nan || s1_q.b.is_nan
                 || (s1_q.a.is_inf && s1_q.b.is_zero)
                 || (s1_q.a.is_zero && s1_q.b.is_inf);
        prod_inf  = !prod_nan && (s1_q.a.is_inf || s1_q.b.is_inf);
        prod_zero = !prod_nan && !prod_inf && (s1_q.a.is_zero || s1_q.b.is_zero);

        // Bubbles stay all-zero so idle output slots read 0 rather than a -127 exponent.
        prod = '0;
        if (s1_q.valid) begin
            prod.valid   = 1'b1;
            prod.meta    = s1_q.meta;
            prod.is_nan  = prod_nan;
            prod.is_inf  = prod_inf;
            prod.is_zero = prod_zero;
            prod.sign    = prod_nan ? 1'b0 : (s1_q.a.sign ^ s1_q.b.sign);
            if (!(prod_nan || prod_inf || prod_zero)) begin
                prod.mant = {24'd0, s1_q.a.m} * {24'd0, s1_q.b.m};
                prod.exp  = {2'b00, s1_q.a.ee} + {2'b00, s1_q.b.ee} - 10'd127;
            end
        end
    end

    always_comb begin
        s2_d = s2_q;
        if (clear[1]) begin
            s2_d = '0;
        end else if (en) begin
            s2_d = prod;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign p_result                = s2_q.valid;
    assign fmul_pipeline_signals_o = s2_q.meta;
    assign prod_sign               = s2_q.sign;
    assign prod_exp                = s2_q.exp;
    assign prod_mant               = s2_q.mant;
    assign prod_is_NaN             = s2_q.is_nan;
    assign prod_is_inf             = s2_q.is_inf;
    assign prod_is_zero            = s2_q.is_zero;

    assign uu_rd[0]        = s1_q.meta.rd;
    assign uu_rd[1]        = s2_q.meta.rd;
    assign uu_reg_write    = {s2_q.meta.reg_write, s1_q.meta.reg_write};
    assign uu_FP_reg_write = {s2_q.meta.FP_reg_write, s1_q.meta.FP_reg_write};

endmodule

// File: tb/tb_fmul_prod_r4.sv
// tb_fmul_prod_r4: scoreboard bench for fmul_prod_r4; directed cases from the
// product rules plus randomized traffic with stalls, flushes and resets.

module tb_fmul_prod_r4;
    import exe_bus_pkg::*;

    logic              clk = 1'b0;
    logic              rst, en, p_start;
    logic [1:0]        clear;
    logic [31:0]       num1, num2;
    exe_p_mux_bus_type meta_i, meta_o;
    logic              p_result, prod_sign, prod_is_NaN, prod_is_inf, prod_is_zero;
    logic [9:0]        prod_exp;
    logic [47:0]       prod_mant;
    logic [4:0]        uu_rd [0:1];
    logic [1:0]        uu_reg_write, uu_FP_reg_write;

    fmul_prod_r4 dut (
        .clk                     (clk),
        .rst                     (rst),
        .en                      (en),
        .clear                   (clear),
        .num1                    (num1),
        .num2                    (num2),
        .p_start                 (p_start),
        .p_result                (p_result),
        .fmul_pipeline_signals_i (meta_i),
        .fmul_pipeline_signals_o (meta_o),
        .prod_sign               (prod_sign),
        .prod_exp                (prod_exp),
        .prod_mant               (prod_mant),
        .prod_is_NaN             (prod_is_NaN),
        .prod_is_inf             (prod_is_inf),
        .prod_is_zero            (prod_is_zero),
        .uu_rd                   (uu_rd),
        .uu_reg_write            (uu_reg_write),
        .uu_FP_reg_write         (uu_FP_reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                id;
        exe_p_mux_bus_type meta;
        logic              sign;
        logic [9:0]        exp;
        logic [47:0]       mant;
        logic              nan;
        logic              inf;
        logic              zero;
    } exp_t;

    exp_t              exp_q[$];
    bit                killed[int];
    exe_p_mux_bus_type meta_of[int];

    int n_checks = 0;
    int n_errors = 0;
    int next_id  = 0;
    int in_id    = -1;
    int s1_id    = -1;
    int s2_id    = -1;
    bit out_new  = 1'b0;
    bit mon_on   = 1'b0;
    bit s1_keep;
    exp_t last_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic [9:0] e, input logic [47:0] m,
                                input logic nan, input logic inf, input logic zero);
        exp_t r;
        r.id = -1; r.meta = '0; r.sign = s; r.exp = e; r.mant = m;
        r.nan = nan; r.inf = inf; r.zero = zero;
        return r;
    endfunction

    // Reference: value-level decode and integer product, straight from the IEEE rules.
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb;
        longint sa, sb;
        bit     na, nb, ia, ib, za, zb;
        exp_t   r;
        r  = mk(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        za = (a[30:0] == 0);
        zb = (b[30:0] == 0);
        if (na || nb || (ia && zb) || (za && ib)) begin
            r.nan = 1'b1;
        end else if (ia || ib) begin
            r.inf  = 1'b1;
            r.sign = a[31] ^ b[31];
        end else if (za || zb) begin
            r.zero = 1'b1;
            r.sign = a[31] ^ b[31];
        end else begin
            sa     = longint'(a[22:0]) + ((ea == 0) ? 64'd0 : 64'd8388608);
            sb     = longint'(b[22:0]) + ((eb == 0) ? 64'd0 : 64'd8388608);
            r.mant = 48'(sa * sb);
            r.exp  = 10'(((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127);
            r.sign = a[31] ^ b[31];
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_operand();
        logic        s = 1'($urandom);
        int          k = $urandom_range(0, 9);
        logic [22:0] f = 23'($urandom);
        case (k)
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, f | 23'd1};
            3:       return {s, 8'h00, f};
            4:       return {s, ($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01, f};
            default: return {s, 8'($urandom_range(1, 254)), f};
        endcase
    endfunction

    // Drives one cycle of inputs just after a rising edge; issued ops go to the scoreboard.
    task automatic step(input logic r, input logic e, input logic [1:0] c, input logic ps,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit use_dir, input exp_t dir);
        exp_t              x;
        exe_p_mux_bus_type m;
        @(posedge clk);
        #1;
        rst = r; en = e; clear = c; p_start = ps; num1 = a; num2 = b;
        if (ps) begin
            m.pc           = $urandom;
            m.fpu_op       = 4'($urandom);
            m.rd           = 5'($urandom);
            m.reg_write    = 1'($urandom);
            m.FP_reg_write = 1'($urandom);
            x              = use_dir ? dir : ref_mul(a, b);
            x.id           = next_id;
            x.meta         = m;
            meta_of[next_id] = m;
            exp_q.push_back(x);
            meta_i         = m;
            in_id          = next_id;
            next_id++;
        end else begin
            meta_i = '0;
            in_id  = -1;
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b);
        step(1'b0, 1'b1, 2'b00, 1'b1, a, b, 1'b0, last_exp);
    endtask

    task automatic dop(input logic [31:0] a, input logic [31:0] b, input exp_t d);
        step(1'b0, 1'b1, 2'b00, 1'b1, a, b, 1'b1, d);
    endtask

    task automatic idle(input logic e, input logic [1:0] c, input logic r);
        step(r, e, c, 1'b0, $urandom, $urandom, 1'b0, last_exp);
    endtask

    // Slot-occupancy model: which issued op sits in S1 / the output slot, and which are lost.
    always @(posedge clk) begin
        if (rst) begin
            if (s1_id >= 0) killed[s1_id] = 1'b1;
            if (in_id >= 0) killed[in_id] = 1'b1;
            s1_id   <= -1;
            s2_id   <= -1;
            out_new <= 1'b0;
        end else begin
            s1_keep = (en && !clear[1]) || (!en && !clear[0]);
            if (s1_id >= 0 && !s1_keep) killed[s1_id] = 1'b1;
            if (in_id >= 0 && !(en && !clear[0])) killed[in_id] = 1'b1;
            s2_id   <= clear[1] ? -1 : (en ? s1_id : s2_id);
            s1_id   <= clear[0] ? -1 : (en ? in_id : s1_id);
            out_new <= !clear[1] && en && (s1_id >= 0);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t              cur;
        exe_p_mux_bus_type em1;
        if (mon_on) begin
            check("p_result", 64'(p_result), 64'(s2_id >= 0));
            em1 = (s1_id >= 0) ? meta_of[s1_id] : '0;
            check("uu_rd_s1", 64'(uu_rd[0]), 64'(em1.rd));
            check("uu_wr_s1", 64'({uu_reg_write[0], uu_FP_reg_write[0]}),
                  64'({em1.reg_write, em1.FP_reg_write}));
            if (s2_id < 0) begin
                cur = mk(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
            end else if (out_new) begin
                while (exp_q.size() > 0 && killed.exists(exp_q[0].id)) void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: output presented with no expected entry at %0t", $time);
                    cur = mk(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                end
                last_exp = cur;
            end else begin
                cur = last_exp;
            end
            check("prod_sign", 64'(prod_sign), 64'(cur.sign));
            check("prod_exp", 64'(prod_exp), 64'(cur.exp));
            check("prod_mant", 64'(prod_mant), 64'(cur.mant));
            check("prod_flags", 64'({prod_is_NaN, prod_is_inf, prod_is_zero}),
                  64'({cur.nan, cur.inf, cur.zero}));
            check("meta_out", 64'(meta_o), 64'(cur.meta));
            check("uu_rd_out", 64'(uu_rd[1]), 64'(cur.meta.rd));
            check("uu_wr_out", 64'({uu_reg_write[1], uu_FP_reg_write[1]}),
                  64'({cur.meta.reg_write, cur.meta.FP_reg_write}));
        end
    end

    initial begin
        int alive;
        rst = 1'b1; en = 1'b0; clear = 2'b00; p_start = 1'b0;
        num1 = '0; num2 = '0; meta_i = '0;
        last_exp = mk(1'b0, 10'd0, 48'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2'b00, 1'b1);
        idle(1'b0, 2'b00, 1'b1);
        mon_on = 1'b1;

        // Directed products and special classes, back-to-back.
        dop(32'h3FC00000, 32'h40000000, mk(1'b0, 10'd128, 48'h600000000000, 1'b0, 1'b0, 1'b0));
        dop(32'h7F800000, 32'h00000000, mk(1'b0, 10'd0, 48'd0, 1'b1, 1'b0, 1'b0));
        dop(32'hFF800000, 32'h40000000, mk(1'b1, 10'd0, 48'd0, 1'b0, 1'b1, 1'b0));
        dop(32'hC0000000, 32'h00000000, mk(1'b1, 10'd0, 48'd0, 1'b0, 1'b0, 1'b1));
        dop(32'h00000001, 32'h3F800000, mk(1'b0, 10'd1, 48'h000000800000, 1'b0, 1'b0, 1'b0));
        dop(32'h00800000, 32'h00800000, mk(1'b0, 10'h383, 48'h400000000000, 1'b0, 1'b0, 1'b0));
        repeat (3) idle(1'b1, 2'b00, 1'b0);

        // Stall: op held for three disabled cycles, emerges on the next enabled edge.
        op(32'h40400000, 32'hC0A00000);
        repeat (3) idle(1'b0, 2'b00, 1'b0);
        repeat (3) idle(1'b1, 2'b00, 1'b0);

        // Flush output slot only, then both slots.
        op(gen_operand(), gen_operand());
        op(gen_operand(), gen_operand());
        step(1'b0, 1'b1, 2'b10, 1'b1, 32'h3F800000, 32'h40000000, 1'b0, last_exp);
        repeat (3) idle(1'b1, 2'b00, 1'b0);
        op(gen_operand(), gen_operand());
        op(gen_operand(), gen_operand());
        step(1'b0, 1'b1, 2'b11, 1'b1, gen_operand(), gen_operand(), 1'b0, last_exp);
        op(32'h41000000, 32'h3E800000);
        repeat (3) idle(1'b1, 2'b00, 1'b0);

        // Reset while two ops are in flight.
        op(gen_operand(), gen_operand());
        op(gen_operand(), gen_operand());
        step(1'b1, 1'b1, 2'b00, 1'b1, gen_operand(), gen_operand(), 1'b0, last_exp);
        repeat (3) idle(1'b1, 2'b00, 1'b0);
        op(gen_operand(), gen_operand());
        repeat (2) idle(1'b1, 2'b00, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 80),
                 {($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 5)},
                 ($urandom_range(0, 99) < 70), gen_operand(), gen_operand(), 1'b0, last_exp);
        end
        repeat (4) idle(1'b1, 2'b00, 1'b0);
        @(posedge clk);

        alive = 0;
        foreach (exp_q[i]) if (!killed.exists(exp_q[i].id)) alive++;
        check("queue_drained", 64'(alive), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fmul_prod_r4.md
# fmul_prod_r4

Two-stage pipelined single-precision multiplier front end that produces the unrounded, unnormalized 48-bit product consumed by the `faddsub_r4` `num1_*` operand port, for fused multiply-add/sub instructions. It sits directly upstream of the add/sub pipeline in the FP execute cluster. It unpacks two IEEE-754 binary32 operands, classifies special values, and forms the exact significand product and biased exponent. It carries the same execute-pipeline metadata bus, valid token and hazard-visibility outputs as the other FP units.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: pipeline advance enable; when low, all registers hold.
- `clear` in 2: per-stage flush. `clear[0]` flushes S1; `clear[1]` flushes S2/output.
- `num1` in 32: binary32 multiplicand.
- `num2` in 32: binary32 multiplier.
- `p_start` in 1: valid token entering S1.
- `p_result` out 1: valid token leaving S2, aligned with product outputs.
- `fmul_pipeline_signals_i` in `exe_p_mux_bus_type`: instruction metadata entering S1.
- `fmul_pipeline_signals_o` out `exe_p_mux_bus_type`: metadata aligned with outputs.
- `prod_sign` out 1: sign of the product.
- `prod_exp` out 10: two's-complement biased exponent (bias 127).
- `prod_mant` out 48: exact significand product, binary point between bits 46 and 45.
- `prod_is_NaN`, `prod_is_inf`, `prod_is_zero` out 1 each: product class.
- `uu_rd` out 5 × [0:1]: `[0]`=S1 rd, `[1]`=output rd.
- `uu_reg_write` out 2: `{out.reg_write, S1.reg_write}`.
- `uu_FP_reg_write` out 2: `{out.FP_reg_write, S1.FP_reg_write}`.

## Operation
- Unpack (combinational before S1), for each operand `x`:
  - `s=x[31]`, `e=x[30:23]`, `f=x[22:0]`.
  - `isNaN = (e==8'hFF && f!=0)`.
  - `isInf = (e==8'hFF && f==0)`.
  - `isZero = (x[30:0]==0)`.
  - `m = {e!=0, f}` (24 bits). Effective exponent `ee = (e==0) ? 1 : e`.
- S1 registers: both signs, `ee1`, `ee2`, `m1`, `m2`, and all six class flags.
- Between S1 and S2, multiply and classify:
  - `prod_mant = m1*m2`, unsigned 24×24 → 48.
  - `prod_exp = {2'b0,ee1} + {2'b0,ee2} − 10'd127`. Range is −125..381, so it never wraps in 10 bits.
  - `prod_sign = s1 ^ s2`.
- Classification, in priority order:
  - NaN if either operand is NaN, or inf×zero in either order.
  - Else inf if either operand is inf.
  - Else zero if either operand is zero.
  - NaN output forces `prod_sign=0`.
- When NaN, inf or zero: `prod_mant=0` and `prod_exp=0`. `prod_sign` stays `s1^s2` for inf/zero.
- Represented value = `prod_mant/2^46 × 2^(prod_exp−127)`. No normalization, rounding or flagging is done here; `faddsub_r4` does those.
- Metadata bus and valid token shift S1→S2 in lockstep with the datapath.

## Timing
- Latency is 2 `en`-qualified cycles: inputs sampled at edge N appear on outputs after edge N+1.
- One operation accepted per enabled cycle; no back-pressure beyond `en`.
- Per-register priority: `rst` > `clear[k]` > `en` > hold.
- Reset: every register goes to 0. All outputs read 0, including `p_result`, metadata, `uu_*`, `prod_*` and flags.
- `clear[0]`: S1 loads 0, including token and metadata, regardless of `en`.
- `clear[1]`: output stage loads 0 regardless of `en`.
- When only one clear bit is set, the other stage still advances if `en=1`. If `en=0`, it holds.
- Simultaneous `clear=2'b11`: both stages zero on the same edge.
- `en=0` with no clear: all outputs stable; `uu_*` keeps reflecting held stages.
- Reset asserted mid-operation: in-flight ops are discarded on that edge. No output pulses after reset deasserts until a new `p_start` propagates.
- Outputs of bubble slots (token=0) are 0, because flushed/reset stages are all-zero.

## Test plan
- Normal product: `num1=0x3FC00000`, `num2=0x40000000`, `p_start=1`, `en=1`. Two edges later: `prod_mant=0x600000000000`, `prod_exp=128`, `prod_sign=0`, flags 0, `p_result=1`.
- Special classes, back-to-back:
  - `0x7F800000×0x00000000` → `prod_is_NaN=1`, `prod_sign=0`.
  - `0xFF800000×0x40000000` → `prod_is_inf=1`, `prod_sign=1`.
  - `0xC0000000×0x00000000` → `prod_is_zero=1`, `prod_sign=1`, mant/exp 0.
- Subnormal: `0x00000001×0x3F800000` → `prod_mant=0x000000800000`, `prod_exp=1`. Also `0x00800000×0x00800000` → `prod_exp=10'h383` (−125).
- Stall: issue an op, drop `en` for 3 cycles, then reassert. Outputs and `uu_rd` are held, result emerges on the 2nd enabled edge, and metadata rd matches the issued rd.
- Flush: three ops in flight; pulse `clear[1]` with `en=1`. The output slot zeroes while the S1 op advances normally. Repeat with `clear=2'b11`: both slots are zero, then the next op emerges after 2 edges.
- Reset mid-stream: assert `rst` for one edge while 2 ops are in flight. Next cycle all outputs are 0, and no `p_result` appears until a fresh `p_start`.
